// File: rtl/weight_ram_bank.sv
// Three-layer weight store: one block RAM per layer with write, burst read and
// saturating read-modify-write update behind a single command port.
module weight_ram_bank #(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int ADDR_WIDTH                    = 11,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_cmd_valid,
  input  logic [1:0]             i_cmd,
  input  logic [LAYER_WIDTH-1:0] i_layer,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic [ADDR_WIDTH-1:0]  i_len,
  input  logic [DATA_WIDTH-1:0]  i_data,
  output logic                   o_cmd_ready,
  output logic                   o_data_valid,
  output logic [LAYER_WIDTH-1:0] o_layer,
  output logic [ADDR_WIDTH-1:0]  o_addr,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_last,
  output logic                   o_error
);
  localparam int D1 = NUMBER_OF_HIDDEN_NODE_LAYER_1 * (NUMBER_OF_INPUT_NODE + 1);
  localparam int D2 = NUMBER_OF_HIDDEN_NODE_LAYER_2 * (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1);
  localparam int D3 = NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1);
  localparam int A1 = $clog2(D1);
  localparam int A2 = $clog2(D2);
  localparam int A3 = $clog2(D3);
  localparam int AW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEP1 = AW'(D1);
  localparam logic [ADDR_WIDTH:0] DEP2 = AW'(D2);
  localparam logic [ADDR_WIDTH:0] DEP3 = AW'(D3);
  localparam logic [LAYER_WIDTH-1:0] L_H1  = LAYER_WIDTH'(1);
  localparam logic [LAYER_WIDTH-1:0] L_H2  = LAYER_WIDTH'(2);
  localparam logic [LAYER_WIDTH-1:0] L_OUT = LAYER_WIDTH'(3);
  localparam logic [1:0] CMD_WR = 2'b00, CMD_BURST = 2'b01, CMD_UPD = 2'b10, CMD_RSV = 2'b11;
  localparam logic [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BURST, UPD} state_t;
  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] mem1 [D1];
  logic [DATA_WIDTH-1:0] mem2 [D2];
  logic [DATA_WIDTH-1:0] mem3 [D3];
  logic [DATA_WIDTH-1:0] rd1, rd2, rd3, rdata;

  logic                   acc, bad;
  logic [ADDR_WIDTH:0]    dlim, end_addr;
  logic                   rd_en, we;
  logic [LAYER_WIDTH-1:0] rd_layer, wr_layer, layer_q, out_layer;
  logic [ADDR_WIDTH-1:0]  rd_addr, wr_addr, out_addr, upd_addr, remain;
  logic [DATA_WIDTH-1:0]  wr_data, delta, hold_data, sat;
  logic [DATA_WIDTH:0]    diff;
  logic                   out_vld, out_last, out_err, ram_beat;

  assign o_cmd_ready = (state == IDLE) && !rst;
  assign acc         = i_cmd_valid && o_cmd_ready;

  always_comb begin
    case (i_layer)
      L_H1:    dlim = DEP1;
      L_H2:    dlim = DEP2;
      L_OUT:   dlim = DEP3;
      default: dlim = '0;
    endcase
  end

  // One extra bit keeps addr+len from wrapping back into range.
  assign end_addr = {1'b0, i_addr} + {1'b0, i_len};
  assign bad = (i_layer == '0) || (i_cmd == CMD_RSV) || ({1'b0, i_addr} >= dlim) ||
               ((i_cmd == CMD_BURST) && ((i_len == '0) || (end_addr > dlim)));

  always_comb begin
    case (layer_q)
      L_H1:    rdata = rd1;
      L_H2:    rdata = rd2;
      default: rdata = rd3;
    endcase
  end

  assign diff = {rdata[DATA_WIDTH-1], rdata} - {delta[DATA_WIDTH-1], delta};
  assign sat  = (diff[DATA_WIDTH] ^ diff[DATA_WIDTH-1]) ? (diff[DATA_WIDTH] ? SMIN : SMAX)
                                                        : diff[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    rd_layer = layer_q;
    rd_addr  = out_addr + ADDR_WIDTH'(1);
    we       = 1'b0;
    wr_layer = i_layer;
    wr_addr  = i_addr;
    wr_data  = i_data;
    case (state)
      IDLE: if (acc && !bad) begin
        case (i_cmd)
          CMD_WR: we = 1'b1;
          CMD_BURST: begin
            rd_en = 1'b1; rd_layer = i_layer; rd_addr = i_addr; state_nx = BURST;
          end
          CMD_UPD: begin
            rd_en = 1'b1; rd_layer = i_layer; rd_addr = i_addr; state_nx = UPD;
          end
          default: ;
        endcase
      end
      BURST: if (remain == ADDR_WIDTH'(1)) state_nx = IDLE;
             else rd_en = 1'b1;
      UPD: begin
        we = 1'b1; wr_layer = layer_q; wr_addr = upd_addr; wr_data = sat; state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (rst) begin
      we    = 1'b0;
      rd_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (we && wr_layer == L_H1)     mem1[wr_addr[A1-1:0]] <= wr_data;
    if (rd_en && rd_layer == L_H1)  rd1 <= mem1[rd_addr[A1-1:0]];
  end
  always_ff @(posedge clk) begin
    if (we && wr_layer == L_H2)     mem2[wr_addr[A2-1:0]] <= wr_data;
    if (rd_en && rd_layer == L_H2)  rd2 <= mem2[rd_addr[A2-1:0]];
  end
  always_ff @(posedge clk) begin
    if (we && wr_layer == L_OUT)    mem3[wr_addr[A3-1:0]] <= wr_data;
    if (rd_en && rd_layer == L_OUT) rd3 <= mem3[rd_addr[A3-1:0]];
  end

  // hold_data keeps o_data stable between beats; ram_beat routes the RAM port straight out.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0; out_last <= 1'b0; out_err <= 1'b0; ram_beat <= 1'b0;
      out_addr <= '0; out_layer <= '0; layer_q <= '0; hold_data <= '0;
      remain <= '0; upd_addr <= '0; delta <= '0;
    end else begin
      out_err <= acc && bad;
      case (state)
        IDLE: begin
          out_vld <= 1'b0; out_last <= 1'b0; ram_beat <= 1'b0;
          if (acc && !bad && i_cmd == CMD_BURST) begin
            out_vld <= 1'b1; out_last <= (i_len == ADDR_WIDTH'(1)); ram_beat <= 1'b1;
            out_addr <= i_addr; out_layer <= i_layer; layer_q <= i_layer; remain <= i_len;
          end else if (acc && !bad && i_cmd == CMD_UPD) begin
            layer_q <= i_layer; upd_addr <= i_addr; delta <= i_data;
          end
        end
        BURST: begin
          hold_data <= rdata;
          if (remain == ADDR_WIDTH'(1)) begin
            out_vld <= 1'b0; out_last <= 1'b0; ram_beat <= 1'b0;
          end else begin
            remain   <= remain - ADDR_WIDTH'(1);
            out_addr <= out_addr + ADDR_WIDTH'(1);
            out_last <= (remain == ADDR_WIDTH'(2));
          end
        end
        UPD: begin
          out_vld <= 1'b1; out_last <= 1'b1; out_addr <= upd_addr;
          out_layer <= layer_q; hold_data <= sat;
        end
        default: ;
      endcase
    end
  end

  assign o_data_valid = out_vld && !rst;
  assign o_last       = out_last && !rst;
  assign o_error      = out_err && !rst;
  assign o_addr       = rst ? '0 : out_addr;
  assign o_layer      = rst ? '0 : out_layer;
  assign o_data       = rst ? '0 : (ram_beat ? rdata : hold_data);
endmodule

// File: tb/tb_weight_ram_bank.sv
// Directed plus randomized checks of weight_ram_bank against a per-layer array model.
`timescale 1ns/1ps
module tb_weight_ram_bank;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_cmd_valid;
  logic [1:0]  i_cmd;
  logic [1:0]  i_layer;
  logic [10:0] i_addr, i_len;
  logic [31:0] i_data;
  logic        o_cmd_ready, o_data_valid, o_last, o_error;
  logic [1:0]  o_layer;
  logic [10:0] o_addr;
  logic [31:0] o_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [3][1056];

  always #5 clk = ~clk;

  weight_ram_bank dut (
    .clk(clk), .rst(rst), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd), .i_layer(i_layer),
    .i_addr(i_addr), .i_len(i_len), .i_data(i_data), .o_cmd_ready(o_cmd_ready),
    .o_data_valid(o_data_valid), .o_layer(o_layer), .o_addr(o_addr), .o_data(o_data),
    .o_last(o_last), .o_error(o_error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic int depth(input logic [1:0] layer);
    case (layer)
      2'd1: return 96;
      2'd2: return 1056;
      2'd3: return 99;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    longint r;
    r = longint'($signed(a)) - longint'($signed(b));
    if (r > 64'sd2147483647) r = 64'sd2147483647;
    if (r < -64'sd2147483648) r = -64'sd2147483648;
    return r[31:0];
  endfunction

  // Issue one command in the current cycle and check every cycle of its response.
  task automatic do_op(input logic [1:0] cmd, input logic [1:0] layer, input logic [10:0] addr,
                       input logic [10:0] len, input logic [31:0] data);
    int a, n, dep, li;
    bit bad;
    logic [31:0] exp;
    a = int'(addr); n = int'(len); dep = depth(layer); li = int'(layer) - 1;
    bad = (layer == 2'd0) || (cmd == 2'd3) || (a >= dep) || (cmd == 2'd1 && (n == 0 || a + n > dep));
    i_cmd_valid = 1'b1; i_cmd = cmd; i_layer = layer; i_addr = addr; i_len = len; i_data = data;
    mid();
    check("ready_at_accept", o_cmd_ready, 1);
    next();
    i_cmd_valid = 1'b0;
    if (bad) begin
      mid();
      check("error_pulse", o_error, 1);
      check("error_no_valid", o_data_valid, 0);
      check("error_ready", o_cmd_ready, 1);
      next();
      mid();
      check("error_one_cycle", o_error, 0);
      next();
      return;
    end
    case (cmd)
      2'd0: begin
        mid();
        check("write_no_valid", o_data_valid, 0);
        check("write_no_error", o_error, 0);
        check("write_ready", o_cmd_ready, 1);
        mdl[li][a] = data;
        next();
      end
      2'd1: begin
        for (int k = 0; k < n; k++) begin
          mid();
          check("beat_valid", o_data_valid, 1);
          check("beat_data", o_data, mdl[li][a+k]);
          check("beat_addr", o_addr, 64'(a + k));
          check("beat_layer", o_layer, layer);
          check("beat_last", o_last, 64'(k == n - 1));
          check("beat_ready_low", o_cmd_ready, 0);
          next();
        end
        mid();
        check("burst_end_valid", o_data_valid, 0);
        check("burst_end_last", o_last, 0);
        check("burst_end_ready", o_cmd_ready, 1);
        check("burst_hold_data", o_data, mdl[li][a+n-1]);
        next();
      end
      default: begin
        exp = sat_sub(mdl[li][a], data);
        mid();
        check("upd_busy_ready", o_cmd_ready, 0);
        check("upd_busy_valid", o_data_valid, 0);
        next();
        mid();
        check("upd_valid", o_data_valid, 1);
        check("upd_last", o_last, 1);
        check("upd_data", o_data, exp);
        check("upd_addr", o_addr, addr);
        check("upd_layer", o_layer, layer);
        check("upd_ready", o_cmd_ready, 1);
        mdl[li][a] = exp;
        next();
      end
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_cmd_valid = 1'b0; i_cmd = '0; i_layer = '0; i_addr = '0; i_len = '0; i_data = '0;
    repeat (3) @(posedge clk);
    #1;
    mid();
    check("rst_ready", o_cmd_ready, 0);
    check("rst_valid", o_data_valid, 0);
    check("rst_last", o_last, 0);
    check("rst_error", o_error, 0);
    check("rst_data", o_data, 0);
    check("rst_addr", o_addr, 0);
    check("rst_layer", o_layer, 0);
    next();
    rst = 1'b0;
    mid();
    check("ready_after_rst", o_cmd_ready, 1);
    next();

    // Fill every layer so any later read has a known model value.
    for (int l = 1; l <= 3; l++)
      for (int a = 0; a < depth(2'(l)); a++)
        do_op(2'd0, 2'(l), 11'(a), 11'd0, $urandom);

    // Single-beat read-after-write.
    do_op(2'd0, 2'd1, 11'd5, 11'd0, 32'h0000_0010);
    do_op(2'd1, 2'd1, 11'd5, 11'd1, 32'h0);

    // Burst ending exactly at the top of hidden2.
    for (int i = 0; i < 4; i++) do_op(2'd0, 2'd2, 11'(1052 + i), 11'd0, 32'(i + 1));
    do_op(2'd1, 2'd2, 11'd1052, 11'd4, 32'h0);

    // Rejected commands, including one that would wrap in 11 bits, then readback.
    do_op(2'd1, 2'd3, 11'd98, 11'd2, 32'h0);
    do_op(2'd0, 2'd0, 11'd7, 11'd0, 32'h1234_5678);
    do_op(2'd1, 2'd1, 11'd0, 11'd0, 32'h0);
    do_op(2'd1, 2'd2, 11'd1000, 11'd2047, 32'h0);
    do_op(2'd3, 2'd1, 11'd3, 11'd1, 32'h0);
    do_op(2'd0, 2'd3, 11'd99, 11'd0, 32'hDEAD_0000);
    do_op(2'd1, 2'd3, 11'd95, 11'd4, 32'h0);
    do_op(2'd1, 2'd1, 11'd0, 11'd8, 32'h0);

    // Saturating updates at both rails and a plain one.
    do_op(2'd0, 2'd1, 11'd40, 11'd0, 32'h7FFF_FFF0);
    do_op(2'd2, 2'd1, 11'd40, 11'd0, 32'hFFFF_FF00);
    do_op(2'd1, 2'd1, 11'd40, 11'd1, 32'h0);
    do_op(2'd0, 2'd3, 11'd0, 11'd0, 32'd5);
    do_op(2'd2, 2'd3, 11'd0, 11'd0, 32'd3);
    do_op(2'd0, 2'd2, 11'd9, 11'd0, 32'h8000_0010);
    do_op(2'd2, 2'd2, 11'd9, 11'd0, 32'h0000_0100);
    do_op(2'd1, 2'd2, 11'd9, 11'd1, 32'h0);

    // Reset on beat 2 of an 8-beat burst.
    i_cmd_valid = 1'b1; i_cmd = 2'd1; i_layer = 2'd2; i_addr = 11'd100; i_len = 11'd8;
    next();
    i_cmd_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mid();
      check("pre_rst_beat", o_data, mdl[1][100+k]);
      next();
    end
    rst = 1'b1;
    mid();
    check("rst_beat_valid", o_data_valid, 0);
    check("rst_beat_last", o_last, 0);
    next();
    rst = 1'b0;
    mid();
    check("post_rst_ready", o_cmd_ready, 1);
    check("post_rst_valid", o_data_valid, 0);
    next();
    mid();
    check("post_rst_quiet", o_data_valid, 0);
    next();
    do_op(2'd1, 2'd2, 11'd100, 11'd8, 32'h0);

    // Reset during an update cycle must suppress the write.
    i_cmd_valid = 1'b1; i_cmd = 2'd2; i_layer = 2'd1; i_addr = 11'd50; i_data = 32'd77;
    next();
    i_cmd_valid = 1'b0;
    rst = 1'b1;
    next();
    rst = 1'b0;
    mid();
    check("upd_abort_valid", o_data_valid, 0);
    next();
    do_op(2'd1, 2'd1, 11'd50, 11'd1, 32'h0);

    // A write held on the command port during a burst is dropped.
    i_cmd_valid = 1'b1; i_cmd = 2'd1; i_layer = 2'd1; i_addr = 11'd10; i_len = 11'd4;
    next();
    i_cmd = 2'd0; i_addr = 11'd20; i_data = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      mid();
      check("held_beat_data", o_data, mdl[0][10+k]);
      next();
    end
    i_cmd_valid = 1'b0;
    do_op(2'd1, 2'd1, 11'd20, 11'd1, 32'h0);

    // Randomized mix, biased toward boundaries and saturation.
    for (int i = 0; i < 300; i++) begin
      logic [1:0] cmd, layer;
      int d, a, n, r;
      logic [31:0] v;
      cmd = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) cmd = 2'd1;
      layer = 2'($urandom_range(0, 3));
      d = (depth(layer) > 0) ? depth(layer) : 99;
      r = $urandom_range(0, 9);
      a = (r == 0) ? d : $urandom_range(0, d - 1);
      if (r == 1) n = 0;
      else if (r == 2) n = d - a + 1;
      else n = $urandom_range(1, ((d - a) < 16) ? ((d - a) > 0 ? d - a : 1) : 16);
      case ($urandom_range(0, 3))
        0: v = 32'h8000_0000;
        1: v = 32'h7FFF_FFFF;
        default: v = $urandom;
      endcase
      do_op(cmd, layer, 11'(a), 11'(n), v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
